// File: rtl/ps2_mouse_ctrl.sv
// PS/2 stream-mode packet assembler and saturating aim-position tracker.
// Frames 3-byte packets with header sync and inter-byte timeout; updates pos_x/pos_y per packet.
module ps2_mouse_ctrl #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int POS_W          = 10,
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             recenter,
  output logic             pkt_valid,
  output logic             btn_left,
  output logic             btn_right,
  output logic             btn_middle,
  output logic [8:0]       dx,
  output logic [8:0]       dy,
  output logic             ovf_x,
  output logic             ovf_y,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             sync_err,
  output logic             timeout_err
);

  // state   | meaning
  // WAIT_B0 | idle, waiting for a header byte (bit3=1)
  // WAIT_B1 | header stored, waiting for X byte
  // WAIT_B2 | X stored, waiting for Y byte to complete the packet

  localparam int                     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]       CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [POS_W-1:0]       X_CTR    = POS_W'(X_MAX / 2);
  localparam logic [POS_W-1:0]       Y_CTR    = POS_W'(Y_MAX / 2);
  localparam logic [POS_W-1:0]       X_TOP    = POS_W'(X_MAX);
  localparam logic [POS_W-1:0]       Y_TOP    = POS_W'(Y_MAX);
  localparam logic signed [POS_W+1:0] X_LIM   = (POS_W+2)'(X_MAX);
  localparam logic signed [POS_W+1:0] Y_LIM   = (POS_W+2)'(Y_MAX);

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [7:0]              r_hdr;
  logic [7:0]              w_hdr_nxt;
  logic [7:0]              r_xb;
  logic [7:0]              w_xb_nxt;
  logic                    w_pkt;
  logic                    w_sync;
  logic                    w_tmo;

  logic                    r_pkt;
  logic                    r_sync;
  logic                    r_tmo;
  logic [2:0]              r_btn;
  logic [8:0]              r_dx;
  logic [8:0]              r_dy;
  logic                    r_ovf_x;
  logic                    r_ovf_y;
  logic [POS_W-1:0]        r_pos_x;
  logic [POS_W-1:0]        r_pos_y;

  logic [8:0]              w_dx;
  logic [8:0]              w_dy;
  logic signed [POS_W+1:0] w_sum_x;
  logic signed [POS_W+1:0] w_sum_y;
  logic [POS_W-1:0]        w_clamp_x;
  logic [POS_W-1:0]        w_clamp_y;
  logic [POS_W-1:0]        w_pos_x_nxt;
  logic [POS_W-1:0]        w_pos_y_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= WAIT_B0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Timeout is a down-counter reloaded on each accepted byte; expiry is an idle sample at zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hdr_nxt   = r_hdr;
    w_xb_nxt    = r_xb;
    w_pkt       = 1'b0;
    w_sync      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      WAIT_B0: begin
        w_cnt_nxt = '0;
        if (rx_valid) begin
          if (rx_data[3]) begin
            w_hdr_nxt   = rx_data;
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = WAIT_B1;
          end else begin
            w_sync = 1'b1;
          end
        end
      end
      WAIT_B1: begin
        if (rx_valid) begin
          w_xb_nxt    = rx_data;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = WAIT_B2;
        end else if (r_cnt == '0) begin
          w_tmo       = 1'b1;
          w_state_nxt = WAIT_B0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      WAIT_B2: begin
        if (rx_valid) begin
          w_pkt       = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = WAIT_B0;
        end else if (r_cnt == '0) begin
          w_tmo       = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = WAIT_B0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT_B0;
      end
    endcase
  end

  // Y is subtracted because PS/2 +Y points up while screen +Y points down.
  always_comb begin
    w_dx    = {r_hdr[4], r_xb};
    w_dy    = {r_hdr[5], rx_data};
    w_sum_x = $signed({2'b00, r_pos_x}) + $signed({{(POS_W-7){w_dx[8]}}, w_dx});
    w_sum_y = $signed({2'b00, r_pos_y}) - $signed({{(POS_W-7){w_dy[8]}}, w_dy});

    if (w_sum_x[POS_W+1]) begin
      w_clamp_x = '0;
    end else if (w_sum_x > X_LIM) begin
      w_clamp_x = X_TOP;
    end else begin
      w_clamp_x = w_sum_x[POS_W-1:0];
    end

    if (w_sum_y[POS_W+1]) begin
      w_clamp_y = '0;
    end else if (w_sum_y > Y_LIM) begin
      w_clamp_y = Y_TOP;
    end else begin
      w_clamp_y = w_sum_y[POS_W-1:0];
    end

    w_pos_x_nxt = r_pos_x;
    w_pos_y_nxt = r_pos_y;
    if (recenter) begin
      w_pos_x_nxt = X_CTR;
      w_pos_y_nxt = Y_CTR;
    end else if (w_pkt) begin
      if (!r_hdr[6]) w_pos_x_nxt = w_clamp_x;
      if (!r_hdr[7]) w_pos_y_nxt = w_clamp_y;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_hdr   <= '0;
      r_xb    <= '0;
      r_pkt   <= 1'b0;
      r_sync  <= 1'b0;
      r_tmo   <= 1'b0;
      r_btn   <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_ovf_x <= 1'b0;
      r_ovf_y <= 1'b0;
      r_pos_x <= X_CTR;
      r_pos_y <= Y_CTR;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_hdr   <= w_hdr_nxt;
      r_xb    <= w_xb_nxt;
      r_pkt   <= w_pkt;
      r_sync  <= w_sync;
      r_tmo   <= w_tmo;
      r_pos_x <= w_pos_x_nxt;
      r_pos_y <= w_pos_y_nxt;
      if (w_pkt) begin
        r_btn   <= r_hdr[2:0];
        r_dx    <= w_dx;
        r_dy    <= w_dy;
        r_ovf_x <= r_hdr[6];
        r_ovf_y <= r_hdr[7];
      end
    end
  end

  assign pkt_valid   = r_pkt;
  assign sync_err    = r_sync;
  assign timeout_err = r_tmo;
  assign btn_left    = r_btn[0];
  assign btn_right   = r_btn[1];
  assign btn_middle  = r_btn[2];
  assign dx          = r_dx;
  assign dy          = r_dy;
  assign ovf_x       = r_ovf_x;
  assign ovf_y       = r_ovf_y;
  assign pos_x       = r_pos_x;
  assign pos_y       = r_pos_y;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Scoreboard bench for ps2_mouse_ctrl: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_ps2_mouse_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       recenter;
  logic       pkt_valid;
  logic       btn_left;
  logic       btn_right;
  logic       btn_middle;
  logic [8:0] dx;
  logic [8:0] dy;
  logic       ovf_x;
  logic       ovf_y;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       sync_err;
  logic       timeout_err;

  ps2_mouse_ctrl #(
    .TIMEOUT_CYCLES(50),
    .POS_W(10),
    .X_MAX(639),
    .Y_MAX(479)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .recenter(recenter),
    .pkt_valid(pkt_valid),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_middle(btn_middle),
    .dx(dx),
    .dy(dy),
    .ovf_x(ovf_x),
    .ovf_y(ovf_y),
    .pos_x(pos_x),
    .pos_y(pos_y),
    .sync_err(sync_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  localparam int K_PKT  = 0;
  localparam int K_SYNC = 1;
  localparam int K_TMO  = 2;

  typedef struct {
    int         kind;
    logic [2:0] btn;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [1:0] ovf;
    logic [9:0] px;
    logic [9:0] py;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  exp_t m_e;
  int   m_kind;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (pkt_valid || sync_err || timeout_err) begin
      m_kind = pkt_valid ? K_PKT : (sync_err ? K_SYNC : K_TMO);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got kind %0d, expected no event at %0t", m_kind, $time);
      end else begin
        m_e = exp_q.pop_front();
        chk("event_kind", 32'(m_kind), 32'(m_e.kind));
        chk("single_pulse", 32'(pkt_valid) + 32'(sync_err) + 32'(timeout_err), 32'd1);
        if (m_e.kind == K_PKT) begin
          chk("buttons", {29'd0, btn_middle, btn_right, btn_left}, {29'd0, m_e.btn});
          chk("dx", {23'd0, dx}, {23'd0, m_e.dx});
          chk("dy", {23'd0, dy}, {23'd0, m_e.dy});
          chk("ovf", {30'd0, ovf_y, ovf_x}, {30'd0, m_e.ovf});
          chk("pos_x", {22'd0, pos_x}, {22'd0, m_e.px});
          chk("pos_y", {22'd0, pos_y}, {22'd0, m_e.py});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic push_evt(input int kind);
    exp_t e;
    e = '{kind: kind, btn: 3'd0, dx: 9'd0, dy: 9'd0, ovf: 2'd0, px: 10'd0, py: 10'd0};
    exp_q.push_back(e);
  endtask

  task automatic push_pkt(input logic [2:0] btn, input logic [8:0] edx, input logic [8:0] edy,
                          input logic [1:0] ovf, input logic [9:0] px, input logic [9:0] py);
    exp_t e;
    e = '{kind: K_PKT, btn: btn, dx: edx, dy: edy, ovf: ovf, px: px, py: py};
    exp_q.push_back(e);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input bit rc,
                          input logic [2:0] btn, input logic [8:0] edx, input logic [8:0] edy,
                          input logic [1:0] ovf, input logic [9:0] px, input logic [9:0] py);
    push_pkt(btn, edx, edy, ovf, px, py);
    send_byte(b0);
    send_byte(b1);
    recenter = rc;
    send_byte(b2);
    recenter = 1'b0;
    chk("pkt_latency", {31'd0, pkt_valid}, 32'd1);
    idle(1);
    chk("pkt_one_cycle", {31'd0, pkt_valid}, 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(2);
  endtask

  initial begin
    reset    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    recenter = 1'b0;
    idle(3);
    chk("rst_pos_x", {22'd0, pos_x}, 32'd319);
    chk("rst_pos_y", {22'd0, pos_y}, 32'd239);
    chk("rst_pulses", {29'd0, pkt_valid, sync_err, timeout_err}, 32'd0);
    chk("rst_fields", {9'd0, btn_middle, btn_right, btn_left, ovf_y, ovf_x, dx, dy}, 32'd0);
    reset = 1'b1;
    idle(2);

    send_pkt(8'h09, 8'h10, 8'h00, 1'b0, 3'b001, 9'h010, 9'h000, 2'b00, 10'd335, 10'd239);
    pulse_reset();
    send_pkt(8'h38, 8'hF0, 8'hFB, 1'b0, 3'b000, 9'h1F0, 9'h1FB, 2'b00, 10'd303, 10'd244);
    pulse_reset();

    // X saturation at X_MAX, then overflow leaves position untouched.
    send_pkt(8'h08, 8'hFF, 8'h00, 1'b0, 3'b000, 9'h0FF, 9'h000, 2'b00, 10'd574, 10'd239);
    send_pkt(8'h08, 8'hFF, 8'h00, 1'b0, 3'b000, 9'h0FF, 9'h000, 2'b00, 10'd639, 10'd239);
    send_pkt(8'h08, 8'hFF, 8'h00, 1'b0, 3'b000, 9'h0FF, 9'h000, 2'b00, 10'd639, 10'd239);
    send_pkt(8'h48, 8'h7F, 8'h00, 1'b0, 3'b000, 9'h07F, 9'h000, 2'b01, 10'd639, 10'd239);

    push_evt(K_SYNC);
    send_byte(8'h00);
    chk("sync_pulse", {31'd0, sync_err}, 32'd1);
    idle(1);
    send_pkt(8'h0A, 8'h01, 8'h01, 1'b0, 3'b010, 9'h001, 9'h001, 2'b00, 10'd639, 10'd238);

    recenter = 1'b1;
    idle(1);
    recenter = 1'b0;
    chk("recenter_x", {22'd0, pos_x}, 32'd319);
    chk("recenter_y", {22'd0, pos_y}, 32'd239);

    push_evt(K_TMO);
    send_byte(8'h08);
    send_byte(8'h10);
    idle(50);
    chk("timeout_pulse", {31'd0, timeout_err}, 32'd1);
    idle(2);
    send_pkt(8'h08, 8'h02, 8'h03, 1'b0, 3'b000, 9'h002, 9'h003, 2'b00, 10'd321, 10'd236);

    // Byte arriving on the last allowed idle cycle must be accepted.
    push_pkt(3'b000, 9'h010, 9'h000, 2'b00, 10'd337, 10'd236);
    send_byte(8'h08);
    send_byte(8'h10);
    idle(49);
    send_byte(8'h00);
    chk("boundary_pkt", {31'd0, pkt_valid}, 32'd1);
    idle(2);

    send_byte(8'h09);
    reset = 1'b0;
    #1;
    chk("midrst_pos_x", {22'd0, pos_x}, 32'd319);
    chk("midrst_pos_y", {22'd0, pos_y}, 32'd239);
    chk("midrst_fields", {22'd0, btn_left, dx}, 32'd0);
    idle(2);
    reset = 1'b1;
    idle(1);
    send_pkt(8'h09, 8'h05, 8'hFE, 1'b0, 3'b001, 9'h005, 9'h0FE, 2'b00, 10'd324, 10'd0);

    send_pkt(8'h09, 8'h03, 8'h01, 1'b1, 3'b001, 9'h003, 9'h001, 2'b00, 10'd319, 10'd239);

    // Low X clamp and high Y clamp.
    send_pkt(8'h18, 8'h00, 8'h00, 1'b0, 3'b000, 9'h100, 9'h000, 2'b00, 10'd63, 10'd239);
    send_pkt(8'h18, 8'h00, 8'h00, 1'b0, 3'b000, 9'h100, 9'h000, 2'b00, 10'd0, 10'd239);
    send_pkt(8'h28, 8'h00, 8'h80, 1'b0, 3'b000, 9'h000, 9'h180, 2'b00, 10'd0, 10'd367);
    send_pkt(8'h28, 8'h00, 8'h80, 1'b0, 3'b000, 9'h000, 9'h180, 2'b00, 10'd0, 10'd479);

    idle(5);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_ctrl.md
# ps2_mouse_ctrl

Sequences the byte stream from the PS/2 receiver into 3-byte stream-mode mouse packets and maintains a saturating on-screen aim position for the archery game. It sits directly downstream of the PS/2 receiver (`output_data`/`out_valid`) and upstream of the game logic and renderer. It also enforces header sync, inter-byte timeout and recentring.

## Interface
- `TIMEOUT_CYCLES`, default 100000: idle `clk` cycles allowed between bytes of one packet (2 ms at 50 MHz).
- `POS_W`, default 10: width of `pos_x`/`pos_y`.
- `X_MAX`, default 639: maximum `pos_x`.
- `Y_MAX`, default 479: maximum `pos_y`.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset. Assertion clears state immediately; deassertion is synchronous to `clk`.
- `rx_data` in 8: byte from the PS/2 receiver.
- `rx_valid` in 1: one-cycle strobe from the PS/2 receiver; `rx_data` is valid while it is high.
- `recenter` in 1: synchronous request to recentre the aim position.
- `pkt_valid` out 1: one-cycle pulse when a complete packet has been accepted.
- `btn_left`, `btn_right`, `btn_middle` out 1 each: button states from the last packet.
- `dx`, `dy` out 9: signed two's-complement motion from the last packet.
- `ovf_x`, `ovf_y` out 1 each: overflow flags from the last packet.
- `pos_x`, `pos_y` out POS_W: aim position.
- `sync_err` out 1: one-cycle pulse when a header byte is rejected.
- `timeout_err` out 1: one-cycle pulse when a partial packet is abandoned.

## Operation
- State machine states: `WAIT_B0`, `WAIT_B1`, `WAIT_B2`.
- `WAIT_B0`:
  - A byte with bit3=1 is stored as the header; go to `WAIT_B1`.
  - A byte with bit3=0 is discarded; pulse `sync_err`; stay in `WAIT_B0`.
- `WAIT_B1`: store the byte as X; go to `WAIT_B2`.
- `WAIT_B2`: assemble the packet; pulse `pkt_valid`; go to `WAIT_B0`.
- Packet decode from header bit positions:
  - bit0 → `btn_left`, bit1 → `btn_right`, bit2 → `btn_middle`.
  - `dx` = {hdr[4], X}; `dy` = {hdr[5], byte2}.
  - bit6 → `ovf_x`, bit7 → `ovf_y`.
- Position update, on the same edge that sets `pkt_valid`:
  - `pos_x` ← clamp(`pos_x` + `dx`, 0, X_MAX).
  - `pos_y` ← clamp(`pos_y` − `dy`, 0, Y_MAX); PS/2 +Y is up, screen +Y is down.
  - Arithmetic is signed, POS_W+2 bits wide, with saturation at both bounds. No wrap-around.
  - If `ovf_x`=1, `pos_x` is unchanged; if `ovf_y`=1, `pos_y` is unchanged. `dx`/`dy` still report the raw values.
- Timeout:
  - A counter runs in `WAIT_B1`/`WAIT_B2` and clears on every accepted byte.
  - After TIMEOUT_CYCLES consecutive cycles without `rx_valid`: go to `WAIT_B0`, pulse `timeout_err`, discard partial bytes.
  - In `WAIT_B0` the counter is held at 0.
- `recenter`:
  - Sets `pos_x`=X_MAX/2 and `pos_y`=Y_MAX/2 (integer division) on the next edge.
  - Does not affect the packet state machine.
- Reset values: state `WAIT_B0`; all pulses, buttons, `dx`, `dy`, `ovf_x`, `ovf_y` = 0; `pos_x`=X_MAX/2, `pos_y`=Y_MAX/2.

## Timing
- `rx_valid` is sampled on every rising edge. Each strobe is consumed exactly once.
- Back-to-back strobes on consecutive cycles are accepted.
- Latency: with byte 2's `rx_valid` high in cycle N, `pkt_valid`, the decoded fields and the updated `pos_x`/`pos_y` are all visible in cycle N+1. `pkt_valid` is high for exactly one cycle.
- `sync_err` is high in the cycle after the rejected byte's strobe.
- `timeout_err` is high in the cycle after the counter reaches TIMEOUT_CYCLES. The state is `WAIT_B0` in that same cycle.
- Simultaneous events:
  - `rx_valid` in the cycle the timeout would expire: the byte is accepted and no timeout occurs.
  - `recenter` in the same cycle as a packet completion: recentre wins for `pos_x`/`pos_y`. `pkt_valid` and the decoded fields still update.
- Reset asserted mid-packet: all outputs are at reset values while `reset`=0. The first byte after release is treated as a header candidate.
- Decoded fields hold their values until the next packet completes.

## Test plan
- Reset, then bytes 0x09, 0x10, 0x00:
  - `pkt_valid` pulses for one cycle.
  - `btn_left`=1, `dx`=+16, `dy`=0.
  - `pos_x` 319→335, `pos_y`=239.
- From reset, bytes 0x38, 0xF0, 0xFB → `dx`=−16, `dy`=−5, `pos_x`=303, `pos_y`=244.
- Saturation and overflow:
  - From reset, send 0x08, 0xFF, 0x00 three times → `pos_x` goes 574, then 639, then stays 639.
  - Then send 0x48, 0x7F, 0x00 → `ovf_x`=1 and `pos_x` stays 639.
- Sync recovery: send 0x00 in `WAIT_B0` → `sync_err` pulses, no `pkt_valid`. A following 0x0A, 0x01, 0x01 is decoded with `btn_right`=1.
- Timeout, using TIMEOUT_CYCLES=50:
  - Send 0x08, 0x10, then idle 50 cycles → `timeout_err` pulses, no `pkt_valid`.
  - Then 0x08, 0x02, 0x03 → `dx`=+2, `dy`=+3.
  - Also strobe a byte exactly on cycle 50 → accepted, no timeout.
- Interrupts:
  - Assert `reset` after byte 1 → `pos_x`/`pos_y` return to 319/239. A subsequent full packet decodes correctly.
  - `recenter` coincident with byte 2 → `pkt_valid`=1 and the position is centred.
